// File: rtl/hazard_unit_mc.sv
// Hazard detection and forwarding for the 5-stage F/D/E/M/W pipeline, with an
// internal multi-cycle divider occupancy sequencer and a saturating stall-cycle counter.
module hazard_unit_mc #(
  parameter int AW       = 5,
  parameter int DIV_LAT  = 36,
  parameter int CW       = 32,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          regwriteE,
  input  logic          regwriteM,
  input  logic          regwriteW,
  input  logic          memtoRegE,
  input  logic          memtoRegM,
  input  logic          branchD,
  input  logic          jrD,
  input  logic          div_startE,
  input  logic          exceptM,
  input  logic          perf_clr,
  input  logic [AW-1:0] rsD,
  input  logic [AW-1:0] rtD,
  input  logic [AW-1:0] rsE,
  input  logic [AW-1:0] rtE,
  input  logic [AW-1:0] waddrE,
  input  logic [AW-1:0] waddrM,
  input  logic [AW-1:0] waddrW,
  output logic          stallF,
  output logic          stallD,
  output logic          stallE,
  output logic          flushD,
  output logic          flushE,
  output logic          flushM,
  output logic [1:0]    forwardAE,
  output logic [1:0]    forwardBE,
  output logic [1:0]    forwardAD,
  output logic [1:0]    forwardBD,
  output logic          div_busy,
  output logic          div_done,
  output logic [CW-1:0] stall_cycles
);

  localparam int CNTW = $clog2(DIV_LAT + 1);
  localparam logic [CNTW-1:0] LAST = CNTW'(DIV_LAT - 1);

  logic [CNTW-1:0] cnt;
  logic            div_act;
  logic            div_hold;
  logic            lw_stall, br_stall, jr_stall, haz;

  function automatic logic match(input logic [AW-1:0] src, input logic we,
                                 input logic [AW-1:0] wa);
    return we && (src == wa) && ((ZERO_REG == 0) || (src != '0));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic m_ok, input logic w_ok);
    if (m_ok)      return 2'b10;
    else if (w_ok) return 2'b01;
    else           return 2'b00;
  endfunction

  assign forwardAE = fwd_sel(match(rsE, regwriteM, waddrM), match(rsE, regwriteW, waddrW));
  assign forwardBE = fwd_sel(match(rtE, regwriteM, waddrM), match(rtE, regwriteW, waddrW));
  // A load in M has no data yet, so D-stage compares cannot take it from M.
  assign forwardAD = fwd_sel(match(rsD, regwriteM, waddrM) && !memtoRegM,
                             match(rsD, regwriteW, waddrW));
  assign forwardBD = fwd_sel(match(rtD, regwriteM, waddrM) && !memtoRegM,
                             match(rtD, regwriteW, waddrW));

  assign lw_stall = memtoRegE && regwriteE &&
                    (match(rsD, 1'b1, waddrE) || match(rtD, 1'b1, waddrE));
  assign br_stall = branchD &&
                    (match(rsD, regwriteE, waddrE) || match(rtD, regwriteE, waddrE) ||
                     (memtoRegM && (match(rsD, regwriteM, waddrM) ||
                                    match(rtD, regwriteM, waddrM))));
  assign jr_stall = jrD &&
                    (match(rsD, regwriteE, waddrE) ||
                     (memtoRegM && match(rsD, regwriteM, waddrM)));
  assign haz      = lw_stall || br_stall || jr_stall;

  // Divider terms are masked while reset is asserted so nothing stalls or reports busy.
  assign div_act  = resetn && div_startE;
  assign div_hold = div_act && (cnt < LAST);
  assign div_done = div_act && (cnt == LAST);
  assign div_busy = div_act && (cnt != LAST);

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    if (exceptM) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
    end else if (div_hold) begin
      // E is frozen, so M receives a bubble; any D hazard is re-evaluated later.
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (haz) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt          <= '0;
      stall_cycles <= '0;
    end else begin
      if (exceptM)       cnt <= '0;
      else if (div_hold) cnt <= cnt + 1'b1;
      else               cnt <= '0;

      if (perf_clr)                          stall_cycles <= '0;
      else if (stallF && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
